des_bus_initiator: RTL

Master-side driver for the DES register bus used by the 8-bit adder block; it is the initiator that the adder's register file responds to. It accepts read/write commands from a local controller through a small command FIFO, serialises them onto the DES bus one transaction at a time, captures read data after a fixed response latency, and returns it through a valid/ready response port. It sits between configuration firmware/sequencing logic and the adder's control (0x0), offset (0x1) and general-purpose (0x2) registers.

---
 rtl/des_bus_initiator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/des_bus_initiator.sv
// rtl/des_bus_initiator.sv - DES register bus initiator with command FIFO
// Queues read/write commands and issues them one at a time on the DES bus; read data returns on a valid/ready port.
module des_bus_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_wr_rd,
  input  logic [2:0]                    i_cmd_address,
  input  logic [7:0]                    i_cmd_value,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [7:0]                    o_rsp_data,
  output logic [2:0]                    o_des_address,
  output logic [7:0]                    o_des_value,
  output logic                          o_des_req_valid,
  output logic                          o_des_wr_rd,
  input  logic [7:0]                    i_des_rd_value,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP, S_GAP} state_t;

  state_t        r_state;
  state_t        w_next;
  state_t        w_after;
  logic [11:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [11:0]   w_head;
  logic          r_cmd_wr;
  logic [2:0]    r_cmd_addr;
  logic [7:0]    r_cmd_value;
  logic [2:0]    r_cnt;
  logic [7:0]    r_rsp_data;

  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_after = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_wr_rd, i_cmd_address, i_cmd_value};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = r_cmd_wr ? w_after : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (r_cnt == 3'(RD_LATENCY - 1)) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_next = w_after;
        end
      end
      S_GAP: begin
        if (r_cnt == 3'(GAP_CYCLES - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_value <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      if (w_pop) begin
        r_cmd_wr    <= w_head[11];
        r_cmd_addr  <= w_head[10:8];
        r_cmd_value <= w_head[11] ? w_head[7:0] : 8'd0;
      end
      if ((r_state == S_WAIT_RD) && (w_next == S_RESP)) begin
        r_rsp_data <= i_des_rd_value;
      end
    end
  end

  always_comb begin
    o_des_req_valid = 1'b0;
    o_rsp_valid     = 1'b0;
    o_busy          = !w_empty;
    case (r_state)
      S_ISSUE: begin
        o_des_req_valid = 1'b1;
        o_busy          = 1'b1;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_busy      = 1'b1;
      end
      S_WAIT_RD, S_GAP: o_busy = 1'b1;
      default: o_busy = !w_empty;
    endcase
  end

  assign o_cmd_ready   = !w_full;
  assign o_fifo_level  = r_count;
  assign o_des_address = r_cmd_addr;
  assign o_des_value   = r_cmd_value;
  assign o_des_wr_rd   = r_cmd_wr;
  assign o_rsp_data    = r_rsp_data;

endmodule
